// File: rtl/qupls_pkg.sv
// Shared Qupls core types: physical register tags and the sizing agreed between
// commit, the free queue and the name supplier.
package QuplsPkg;

  localparam int PREGS = 512;
  typedef logic [$clog2(PREGS)-1:0] pregno_t;

  localparam int QFREE_NIN    = 8;
  localparam int QFREE_DEPTH  = 32;
  localparam int QFREE_NFTAGS = 4;

endpackage

// File: rtl/qupls_lane_compact.sv
// Prefix count over a multi-lane accept mask: each lane's slot offset among the
// accepted lanes, plus the total number accepted.
module qupls_lane_compact #(
  parameter int NIN = 8
) (
  input  logic [NIN-1:0]                      i_accept,
  output logic [NIN-1:0][$clog2(NIN+1)-1:0]   o_offset,
  output logic [$clog2(NIN+1)-1:0]            o_npush
);

  localparam int CW = $clog2(NIN+1);

  always_comb begin
    logic [CW-1:0] w_sum;
    w_sum    = '0;
    o_offset = '0;
    for (int i = 0; i < NIN; i++) begin
      o_offset[i] = w_sum;
      w_sum       = w_sum + CW'(i_accept[i]);
    end
    o_npush = w_sum;
  end

endmodule

// File: rtl/qupls_preg_free_queue.sv
// Buffers physical register tags released at commit and drains them to the
// name supplier at up to NFTAGS per clock in strict FIFO order.
module qupls_preg_free_queue
  import QuplsPkg::*;
#(
  parameter int NIN    = QFREE_NIN,
  parameter int NFTAGS = QFREE_NFTAGS,
  parameter int DEPTH  = QFREE_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  pregno_t [NIN-1:0]           free_tag,
  input  logic [NIN-1:0]              free_v,
  output logic                        rdy,
  output pregno_t [NFTAGS-1:0]        tags2free,
  output logic [NFTAGS-1:0]           freevals,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        ovf
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = $clog2(NIN+1);
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] NIN_C   = CNTW'(NIN);
  localparam logic [CNTW-1:0] NFT_C   = CNTW'(NFTAGS);

  pregno_t           r_buf [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CNTW-1:0]   r_count;
  logic              r_ovf;

  logic [NIN-1:0]           w_accept;
  logic [NIN-1:0][CW-1:0]   w_offset;
  logic [CW-1:0]            w_npush;
  logic                     w_push;
  logic [CNTW-1:0]          w_nadd;
  logic [CNTW-1:0]          w_npop;

  // Tag 0 is reserved, so a valid lane carrying it is simply dropped.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NIN; i++)
      w_accept[i] = free_v[i] && (free_tag[i] != '0);
  end

  qupls_lane_compact #(.NIN(NIN)) u_compact (
    .i_accept (w_accept),
    .o_offset (w_offset),
    .o_npush  (w_npush)
  );

  assign rdy    = (DEPTH_C - r_count) >= NIN_C;
  assign w_push = rdy && (|w_accept);
  assign w_nadd = w_push ? CNTW'(w_npush) : '0;
  assign w_npop = (r_count > NFT_C) ? NFT_C : r_count;
  assign count  = r_count;
  assign ovf    = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PW'(w_npop);
      r_wr_ptr <= r_wr_ptr + PW'(w_nadd);
      r_count  <= r_count + w_nadd - w_npop;
      if (!rdy && (|w_accept))
        r_ovf <= 1'b1;
    end
  end

  // A rejected cycle writes nothing, so no partial burst lands in the buffer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int i = 0; i < NIN; i++)
        if (w_accept[i])
          r_buf[r_wr_ptr + PW'(w_offset[i])] <= free_tag[i];
    end
  end

  always_comb begin
    tags2free = '0;
    freevals  = '0;
    for (int j = 0; j < NFTAGS; j++) begin
      if (CNTW'(j) < w_npop) begin
        tags2free[j] = r_buf[r_rd_ptr + PW'(j)];
        freevals[j]  = 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (r_count <= DEPTH_C);
      for (int i = 0; i < NIN; i++)
        for (int k = i + 1; k < NIN; k++)
          if (w_accept[i] && w_accept[k])
            assert (free_tag[i] != free_tag[k]);
    end
  end
`endif

endmodule

// File: tb/tb_qupls_preg_free_queue.sv
// Directed bench for the free queue: a scoreboard queue of expected tags is
// filled by the stimulus side and drained by a monitor watching freevals.
module tb_qupls_preg_free_queue;
  import QuplsPkg::*;

  logic             clk = 1'b0;
  logic             rst;
  pregno_t [7:0]    free_tag;
  logic [7:0]       free_v;
  logic             rdy;
  pregno_t [3:0]    tags2free;
  logic [3:0]       freevals;
  logic [5:0]       count;
  logic             ovf;

  int      tests = 0;
  int      fails = 0;
  pregno_t expQ[$];
  int      mCount = 0;
  bit      monEn = 1'b0;
  int      popCount = 0;

  qupls_preg_free_queue dut (
    .clk       (clk),
    .rst       (rst),
    .free_tag  (free_tag),
    .free_v    (free_v),
    .rdy       (rdy),
    .tags2free (tags2free),
    .freevals  (freevals),
    .count     (count),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of lanes; the model is advanced after the edge consumes them.
  task automatic applyStimulus(input logic [7:0] v, input pregno_t [7:0] t);
    int np;
    bit mRdy;
    free_v   = v;
    free_tag = t;
    @(posedge clk);
    mRdy = (32 - mCount) >= 8;
    np = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i] && t[i] != '0) begin
        if (mRdy) expQ.push_back(t[i]);
        np++;
      end
    end
    mCount = mCount + (mRdy ? np : 0) - ((mCount < 4) ? mCount : 4);
    #1 free_v = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      mCount = mCount - ((mCount < 4) ? mCount : 4);
      #1;
    end
  endtask

  always @(negedge clk) begin
    int ex;
    pregno_t e;
    if (monEn && !rst) begin
      ex = (mCount < 4) ? mCount : 4;
      tests++;
      if (freevals != 4'((1 << ex) - 1)) begin
        fails++;
        $display("[TB] FAIL mon_freevals: got %b, expected %b", freevals, 4'((1 << ex) - 1));
      end
      for (int j = 0; j < 4; j++) begin
        tests++;
        if (freevals[j]) begin
          if (expQ.size() == 0) begin
            fails++;
            $display("[TB] FAIL mon_tag%0d: got %0d, expected nothing queued", j, tags2free[j]);
          end else begin
            e = expQ.pop_front();
            popCount++;
            if (tags2free[j] != e) begin
              fails++;
              $display("[TB] FAIL mon_tag%0d: got %0d, expected %0d", j, tags2free[j], e);
            end
          end
        end else if (tags2free[j] != '0) begin
          fails++;
          $display("[TB] FAIL mon_idle_tag%0d: got %0d, expected 0", j, tags2free[j]);
        end
      end
    end
  end

  initial begin
    pregno_t [7:0] t;
    logic [7:0]    v;
    logic [7:0]    masks [8];
    int            nextTag;
    int            popStart;
    int            iter;

    rst = 1'b1;
    free_v = '0;
    free_tag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    monEn = 1'b1;

    checkOutput("reset_count", count, 0);
    checkOutput("reset_rdy", rdy, 1);
    checkOutput("reset_ovf", ovf, 0);
    checkOutput("reset_freevals", freevals, 0);
    for (int k = 0; k < 10; k++) begin
      idle(1);
      checkOutput("idle_freevals", freevals, 0);
      checkOutput("idle_count", count, 0);
    end

    for (int i = 0; i < 8; i++) t[i] = pregno_t'(5 + i);
    applyStimulus(8'hFF, t);
    checkOutput("burst_count", count, 8);
    checkOutput("burst_fv1", freevals, 4'hF);
    checkOutput("burst_tag0", tags2free[0], 5);
    checkOutput("burst_tag3", tags2free[3], 8);
    idle(1);
    checkOutput("burst_fv2", freevals, 4'hF);
    checkOutput("burst_tag4", tags2free[0], 9);
    checkOutput("burst_tag7", tags2free[3], 12);
    idle(1);
    checkOutput("burst_fv3", freevals, 0);
    checkOutput("burst_count_end", count, 0);

    t = '0;
    t[0] = 0; t[1] = 1; t[2] = 33; t[3] = 2; t[4] = 4; t[5] = 40; t[6] = 3; t[7] = 99;
    applyStimulus(8'b1010_0101, t);
    checkOutput("sparse_count", count, 3);
    checkOutput("sparse_fv", freevals, 4'b0111);
    checkOutput("sparse_tag0", tags2free[0], 33);
    checkOutput("sparse_tag1", tags2free[1], 40);
    checkOutput("sparse_tag2", tags2free[2], 99);
    checkOutput("sparse_tag3", tags2free[3], 0);
    checkOutput("sparse_ovf", ovf, 0);
    idle(1);

    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 8; i++) t[i] = pregno_t'(100 + 8 * c + i);
      applyStimulus(8'hFF, t);
    end
    checkOutput("bp_count28", count, 28);
    checkOutput("bp_rdy_low", rdy, 0);
    checkOutput("bp_ovf_before", ovf, 0);
    for (int i = 0; i < 8; i++) t[i] = pregno_t'(150 + i);
    applyStimulus(8'hFF, t);
    checkOutput("bp_ovf_set", ovf, 1);
    checkOutput("bp_count24", count, 24);
    checkOutput("bp_rdy_back", rdy, 1);
    idle(8);
    checkOutput("bp_drained", count, 0);
    checkOutput("bp_ovf_sticky", ovf, 1);

    masks[0] = 8'hFF; masks[1] = 8'h0F; masks[2] = 8'hA5; masks[3] = 8'h81;
    masks[4] = 8'h3C; masks[5] = 8'h00; masks[6] = 8'h7E; masks[7] = 8'hFF;
    nextTag = 1;
    popStart = popCount;
    iter = 0;
    while (nextTag <= 200 && iter < 500) begin
      if ((32 - mCount) >= 8) begin
        t = '0;
        v = '0;
        for (int i = 0; i < 8; i++) begin
          if (masks[iter % 8][i] && nextTag <= 200) begin
            t[i] = pregno_t'(nextTag);
            v[i] = 1'b1;
            nextTag++;
          end
        end
        applyStimulus(v, t);
      end else begin
        idle(1);
      end
      iter++;
    end
    idle(12);
    checkOutput("wrap_popped", popCount - popStart, 200);
    checkOutput("wrap_count", count, 0);

    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 8; i++) t[i] = pregno_t'(210 + 8 * c + i);
      applyStimulus(8'hFF, t);
    end
    checkOutput("mid_count20", count, 20);
    rst = 1'b1;
    expQ.delete();
    mCount = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_count", count, 0);
    checkOutput("rst_freevals", freevals, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_rdy", rdy, 1);
    t = '0;
    t[0] = 301; t[1] = 302; t[2] = 303;
    applyStimulus(8'h07, t);
    checkOutput("post_rst_fv", freevals, 4'b0111);
    checkOutput("post_rst_tag0", tags2free[0], 301);
    checkOutput("post_rst_tag2", tags2free[2], 303);
    idle(2);

    monEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
